// File: rtl/latch_drive_seq.sv
// ---------------------------------------------------------------------------
// latch_drive_seq
//
// Purpose:
//   Writer-side sequencer for a bank of SETN-presettable D-latches. It takes
//   one request at a time from synchronous control logic and produces
//   registered, glitch-free D / E / SETN waveforms. The waveforms respect the
//   latch setup, enable pulse width, hold, preset pulse width and preset
//   recovery windows, each counted in whole clock cycles.
//
// Parameters:
//   WIDTH        - data bus width (d and req_data)
//   SETUP_CYC    - cycles d is stable before e rises            (>= 1)
//   PULSE_CYC    - cycles e is held high                        (>= 1)
//   HOLD_CYC     - cycles d is held after e falls               (>= 1)
//   SETPULSE_CYC - cycles setn is held low for a preset         (>= 1)
//   REC_CYC      - cycles after setn rises before completion    (>= 1)
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   req_valid in   request present
//   req_set   in   1 = preset, 0 = write; sampled with req_valid
//   req_data  in   write data, ignored for presets
//   req_ready out  sequencer idle and able to accept a request
//   d         out  latch data bus
//   e         out  latch enable, active high
//   setn      out  latch preset, active low
//   done      out  one-cycle pulse when an operation completes
// ---------------------------------------------------------------------------
module latch_drive_seq #(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYC    = 1,
    parameter int PULSE_CYC    = 2,
    parameter int HOLD_CYC     = 1,
    parameter int SETPULSE_CYC = 2,
    parameter int REC_CYC      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_set,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    output logic [WIDTH-1:0] d,
    output logic             e,
    output logic             setn,
    output logic             done
);

    // Every timing window needs at least one cycle; a zero-length window
    // would let E and SETN edges collide with the D change or each other.
    generate
        if (WIDTH < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 ||
            SETPULSE_CYC < 1 || REC_CYC < 1) begin : g_bad_params
            $error("latch_drive_seq: WIDTH and all *_CYC parameters must be >= 1");
        end
    endgenerate

    // The single shared down-counter must hold the largest reload value,
    // which is (largest parameter - 1).
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (HOLD_CYC > SETPULSE_CYC) ? HOLD_CYC : SETPULSE_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > REC_CYC) ? MAX_C : REC_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // A state is left on the edge where the counter is already zero, so a
    // reload of N-1 on entry gives exactly N cycles of residency.
    localparam logic [CNT_W-1:0] LD_SETUP    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE    = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETPULSE = CNT_W'(SETPULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_REC      = CNT_W'(REC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        S_LOW   = 3'd4,
        S_REC   = 3'd5
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]   d_q, d_n;
    logic               e_q, e_n;
    logic               setn_q, setn_n;
    logic               done_q, done_n;
    logic               ready_q, ready_n;

    // State, counter and every output live in this one register bank, so
    // all outputs are flop-driven and no input reaches an output
    // combinationally. Reset drops E and releases SETN immediately,
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            e_q     <= 1'b0;
            setn_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            d_q     <= d_n;
            e_q     <= e_n;
            setn_q  <= setn_n;
            done_q  <= done_n;
            ready_q <= ready_n;
        end
    end

    // Next-state and next-output logic. Defaults hold every output, clear
    // the done pulse and let the counter run down toward zero; each state
    // only overrides what changes on its exit edge. A request is accepted
    // only when the registered ready is already high, which is why ready
    // comes up one edge after reset release and the idle gap between
    // back-to-back operations is exactly one cycle.
    always_comb begin
        state_n = state_q;
        cnt_n   = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
        d_n     = d_q;
        e_n     = e_q;
        setn_n  = setn_q;
        done_n  = 1'b0;
        ready_n = ready_q;

        case (state_q)
            IDLE: begin
                ready_n = 1'b1;
                if (ready_q && req_valid) begin
                    ready_n = 1'b0;
                    if (req_set) begin
                        setn_n  = 1'b0;
                        cnt_n   = LD_SETPULSE;
                        state_n = S_LOW;
                    end else begin
                        d_n     = req_data;
                        e_n     = 1'b0;
                        cnt_n   = LD_SETUP;
                        state_n = W_SETUP;
                    end
                end
            end

            W_SETUP: begin
                if (cnt_q == '0) begin
                    e_n     = 1'b1;
                    cnt_n   = LD_PULSE;
                    state_n = W_PULSE;
                end
            end

            W_PULSE: begin
                if (cnt_q == '0) begin
                    e_n     = 1'b0;
                    cnt_n   = LD_HOLD;
                    state_n = W_HOLD;
                end
            end

            W_HOLD: begin
                if (cnt_q == '0) begin
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            S_LOW: begin
                if (cnt_q == '0) begin
                    setn_n  = 1'b1;
                    cnt_n   = LD_REC;
                    state_n = S_REC;
                end
            end

            S_REC: begin
                if (cnt_q == '0) begin
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            default: begin
                e_n     = 1'b0;
                setn_n  = 1'b1;
                ready_n = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign req_ready = ready_q;
    assign d         = d_q;
    assign e         = e_q;
    assign setn      = setn_q;
    assign done      = done_q;

endmodule

// File: tb/tb_latch_drive_seq.sv
// ---------------------------------------------------------------------------
// tb_latch_drive_seq
//
// Directed bench for latch_drive_seq. Instance "dut" uses the default
// timing (1/2/1/2/1); instance "dut_b" uses SETUP=3, PULSE=1, HOLD=4 for
// the parameter sweep. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_latch_drive_seq;

    logic       clk;
    logic       rst;

    logic       req_valid;
    logic       req_set;
    logic [7:0] req_data;
    logic       req_ready;
    logic [7:0] d;
    logic       e;
    logic       setn;
    logic       done;

    logic       req_valid_b;
    logic       req_set_b;
    logic [7:0] req_data_b;
    logic       req_ready_b;
    logic [7:0] d_b;
    logic       e_b;
    logic       setn_b;
    logic       done_b;

    int checks;
    int failures;
    int overlaps;
    int done_count;

    latch_drive_seq #(
        .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1),
        .SETPULSE_CYC(2), .REC_CYC(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_set(req_set), .req_data(req_data),
        .req_ready(req_ready), .d(d), .e(e), .setn(setn), .done(done)
    );

    latch_drive_seq #(
        .WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4),
        .SETPULSE_CYC(2), .REC_CYC(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_set(req_set_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .d(d_b), .e(e_b), .setn(setn_b), .done(done_b)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // E high while SETN low would fight inside the latch; count any cycle
    // where either instance shows that combination.
    always @(negedge clk) begin
        if (e && !setn)
            overlaps++;
        if (e_b && !setn_b)
            overlaps++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] dat);
        req_valid = v;
        req_set   = s;
        req_data  = dat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        overlaps    = 0;
        done_count  = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        req_valid_b = 1'b0;
        req_set_b   = 1'b0;
        req_data_b  = 8'h00;

        // ---------------- reset values ----------------
        tick;
        tick;
        checkOutput("rst_d",     32'(d),         32'h00);
        checkOutput("rst_e",     32'(e),         32'h0);
        checkOutput("rst_setn",  32'(setn),      32'h1);
        checkOutput("rst_done",  32'(done),      32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready_noedge", 32'(req_ready), 32'h0);
        tick;
        checkOutput("rel_ready",   32'(req_ready),   32'h1);
        checkOutput("rel_ready_b", 32'(req_ready_b), 32'h1);

        // ---------------- single write 0xA5, busy requests ignored -------
        applyStimulus(1'b1, 1'b0, 8'hA5);
        tick;                                   // edge 0: accept
        checkOutput("w_e0_d",     32'(d),         32'hA5);
        checkOutput("w_e0_e",     32'(e),         32'h0);
        checkOutput("w_e0_ready", 32'(req_ready), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        tick;                                   // edge 1
        checkOutput("w_e1_e", 32'(e), 32'h1);
        checkOutput("w_e1_d", 32'(d), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'h77);
        tick;                                   // edge 2
        checkOutput("w_e2_e", 32'(e), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'hC3);
        tick;                                   // edge 3
        checkOutput("w_e3_e",    32'(e),    32'h0);
        checkOutput("w_e3_d",    32'(d),    32'hA5);
        checkOutput("w_e3_done", 32'(done), 32'h0);
        tick;                                   // edge 4
        checkOutput("w_e4_done",  32'(done),      32'h1);
        checkOutput("w_e4_ready", 32'(req_ready), 32'h1);
        checkOutput("w_e4_d",     32'(d),         32'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick;                                   // edge 5
        checkOutput("w_e5_done", 32'(done), 32'h0);
        checkOutput("w_e5_d",    32'(d),    32'hA5);

        // ---------------- back-to-back: 0x11, 0x22, preset ----------------
        applyStimulus(1'b1, 1'b0, 8'h11);
        done_count = 0;
        for (int n = 0; n <= 14; n++) begin
            tick;
            if (done)
                done_count++;
            checkOutput($sformatf("b2b_done_e%0d", n), 32'(done),
                        (n == 4 || n == 9 || n == 13) ? 32'h1 : 32'h0);
            if (n == 0)  checkOutput("b2b_d_e0",     32'(d),    32'h11);
            if (n == 5)  checkOutput("b2b_d_e5",     32'(d),    32'h22);
            if (n == 10) checkOutput("b2b_setn_e10", 32'(setn), 32'h0);
            if (n == 13) checkOutput("b2b_d_e13",    32'(d),    32'h22);
            if (n + 1 >= 14)
                applyStimulus(1'b0, 1'b0, 8'h00);
            else if (n + 1 >= 10)
                applyStimulus(1'b1, 1'b1, 8'hEE);
            else if (n + 1 >= 5)
                applyStimulus(1'b1, 1'b0, 8'h22);
            else
                applyStimulus(1'b1, 1'b0, 8'h11);
        end
        checkOutput("b2b_done_count", 32'(done_count), 32'd3);
        checkOutput("b2b_idle_ready", 32'(req_ready),  32'h1);

        // ---------------- write 0x3C to prepare the preset test ----------
        applyStimulus(1'b1, 1'b0, 8'h3C);
        tick;
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done)
                break;
        end
        checkOutput("w3c_done", 32'(done), 32'h1);

        // ---------------- preset with D = 0x3C ----------------------------
        applyStimulus(1'b1, 1'b1, 8'hFF);
        tick;                                   // edge 0
        checkOutput("p_e0_setn",  32'(setn),      32'h0);
        checkOutput("p_e0_e",     32'(e),         32'h0);
        checkOutput("p_e0_d",     32'(d),         32'h3C);
        checkOutput("p_e0_ready", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick;                                   // edge 1
        checkOutput("p_e1_setn", 32'(setn), 32'h0);
        tick;                                   // edge 2
        checkOutput("p_e2_setn", 32'(setn), 32'h1);
        checkOutput("p_e2_done", 32'(done), 32'h0);
        tick;                                   // edge 3
        checkOutput("p_e3_done", 32'(done), 32'h1);
        checkOutput("p_e3_d",    32'(d),    32'h3C);
        checkOutput("p_e3_e",    32'(e),    32'h0);

        // ---------------- parameter sweep on dut_b (3/1/4) ----------------
        req_valid_b = 1'b1;
        req_set_b   = 1'b0;
        req_data_b  = 8'h96;
        tick;                                   // edge 0
        checkOutput("sw_e0_d", 32'(d_b), 32'h96);
        checkOutput("sw_e0_e", 32'(e_b), 32'h0);
        req_valid_b = 1'b0;
        req_data_b  = 8'h00;
        for (int n = 1; n <= 8; n++) begin
            tick;
            checkOutput($sformatf("sw_e_e%0d", n),    32'(e_b),
                        (n == 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sw_done_e%0d", n), 32'(done_b),
                        (n == 8) ? 32'h1 : 32'h0);
        end
        checkOutput("sw_d_end", 32'(d_b), 32'h96);

        // ---------------- reset mid-operation -----------------------------
        applyStimulus(1'b1, 1'b0, 8'h5A);
        req_valid_b = 1'b1;
        req_set_b   = 1'b1;
        tick;                                   // edge 0
        applyStimulus(1'b0, 1'b0, 8'h00);
        req_valid_b = 1'b0;
        req_set_b   = 1'b0;
        tick;                                   // edge 1: e high, setn_b low
        checkOutput("mid_e_high",    32'(e),      32'h1);
        checkOutput("mid_setn_low",  32'(setn_b), 32'h0);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_e",       32'(e),           32'h0);
        checkOutput("mid_rst_setn",    32'(setn),        32'h1);
        checkOutput("mid_rst_d",       32'(d),           32'h00);
        checkOutput("mid_rst_ready",   32'(req_ready),   32'h0);
        checkOutput("mid_rst_setn_b",  32'(setn_b),      32'h1);
        checkOutput("mid_rst_ready_b", 32'(req_ready_b), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_ready_noedge", 32'(req_ready), 32'h0);
        tick;
        checkOutput("mid_rel_ready",   32'(req_ready),   32'h1);
        checkOutput("mid_rel_ready_b", 32'(req_ready_b), 32'h1);
        checkOutput("mid_rel_e",       32'(e),           32'h0);

        // ---------------- invariant: E never overlaps SETN low ------------
        checkOutput("no_e_setn_overlap", 32'(overlaps), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
